xfire_in_fifo: RTL and testbench
================================

Name: xfire_in_fifo

Overview:
Input buffering stage directly upstream of xfire_core. It accepts words from the upstream source over a valid/ready handshake and stores them in a small register-based FIFO. It presents them to xfire_core first-word-fall-through, so the core consumes one word per cycle of its own pace. It also provides fill-level status for flow control and debug.

Parameters:
DATA_W, 16, width of data words in bits (>=1).
DEPTH, 4, number of storage entries; power of two, >=2.
AFULL_TH, 3, almost_full asserted when count >= AFULL_TH; 1..DEPTH.

Ports:
clk  in  1  posedge active clock; only clock of the block.
srst  in  1  synchronous reset, active high, sampled on posedge clk.
enable  in  1  synchronous enable; low freezes all state and blocks both handshakes.
in_data  in  DATA_W  upstream data word.
in_valid  in  1  upstream word present.
in_ready  out  1  block can accept a word this cycle.
out_data  out  DATA_W  word at FIFO head, to xfire_core.
out_valid  out  1  head word valid.
out_ready  in  1  xfire_core takes the head word this cycle.
count  out  $clog2(DEPTH+1)  number of stored words.
almost_full  out  1  count >= AFULL_TH (registered).
overflow  out  1  sticky: push attempted while full (registered).

Behaviour:
- Clock/reset: single clock clk; reset srst is synchronous and active high, no asynchronous reset. srst has priority over enable and all handshakes.
- Reset state: wr_ptr = rd_ptr = 0, count = 0, almost_full = 0, overflow = 0. Hence in_ready = enable, out_valid = 0. Storage contents are not reset; out_data is don't-care while out_valid = 0.
- Combinational outputs:
  - in_ready = enable & (count != DEPTH).
  - out_valid = enable & (count != 0).
  - out_data = mem[rd_ptr].
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- On push: mem[wr_ptr] <= in_data, and wr_ptr advances by 1 modulo DEPTH.
- On pop: rd_ptr advances by 1 modulo DEPTH.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged. This is legal at every non-full, non-empty level. When empty, only push can occur. When full, only pop can occur: in_ready is low, so no same-cycle push-through at full.
- Latency: a word pushed in cycle N appears on out_data with out_valid = 1 in cycle N+1 if the FIFO was empty. There is no combinational bypass from in_* to out_*.
- Ordering: strict FIFO, with no loss or duplication across pointer wrap-around.
- almost_full: registered from next-state count, so it is valid in the same cycle as the count it describes.
- overflow: set when in_valid = 1 and count = DEPTH and enable = 1. It stays set until srst. The dropped word does not alter state.
- enable = 0:
  - No push, no pop, pointers/count/flags hold.
  - in_ready = 0 and out_valid = 0.
  - in_valid or out_ready toggling has no effect.
  - overflow is not set.
- Reset mid-operation: srst asserted with the FIFO partially full discards all contents. The next cycle shows count = 0 and out_valid = 0. A push in the srst cycle is ignored.
- Upstream rule: in_data must be held stable while in_valid = 1 and in_ready = 0. The block does not check this.
- Debug: under RTL_DEBUG, the following are flagged as errors:
  - count > DEPTH;
  - push while full;
  - pop while empty;
  - count disagreeing with (wr_ptr - rd_ptr) mod DEPTH plus a full flag.

Test Plan (DATA_W=16, DEPTH=4, AFULL_TH=3):
1. Reset: srst high for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, overflow = 0 after release; in_ready = 1 with enable = 1.
2. Fill/drain: out_ready = 0, push 0x0001..0x0004 -> count 1, 2, 3, 4; almost_full rises with count = 3; in_ready = 0 at count = 4. Then out_ready = 1 -> out_data reads 0x0001..0x0004 in order, and count returns to 0.
3. Latency/streaming: single push 0xABCD at cycle N into empty FIFO -> out_valid = 1 with out_data = 0xABCD at N+1. Continuous push and pop for 20 cycles -> count stays at 1, data is in order across 5 pointer wraps.
4. Full overflow: with FIFO full, hold in_valid = 1 with 0xDEAD -> overflow = 1 next cycle, count stays 4, and the drained data excludes 0xDEAD. overflow stays 1 until srst.
5. Enable freeze: with count = 2, drop enable for 3 cycles while toggling in_valid and out_ready -> in_ready = 0, out_valid = 0, count stays 2. After enable returns, the same two words are output in order.
6. Reset mid-stream: with count = 3, assert srst together with a push and pop -> count = 0 and out_valid = 0 next cycle. A later push of 0x1234 is output first.

Source files
------------

// File: rtl/xfire_in_fifo.sv
// Register-based first-word-fall-through input FIFO feeding xfire_core.
// Valid/ready on both sides, with a fill count, a registered almost_full flag and a sticky overflow flag.
module xfire_in_fifo #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         enable,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_afull;
    logic              r_ovf;

    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign in_ready    = enable & ~w_full;
    assign out_valid   = enable & ~w_empty;
    assign out_data    = r_mem[r_rd_ptr];
    assign w_push      = in_valid & in_ready;
    assign w_pop       = out_valid & out_ready;
    assign count       = r_count;
    assign almost_full = r_afull;
    assign overflow    = r_ovf;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_afull <= (w_count_nxt >= AF_CNT);
            if (enable & in_valid & w_full) r_ovf <= 1'b1;
        end
    end

    // Storage is not reset; a push coinciding with srst is discarded.
    always_ff @(posedge clk) begin
        if (w_push & ~srst) r_mem[r_wr_ptr] <= in_data;
    end

`ifdef RTL_DEBUG
    logic [PTR_W-1:0] w_dbg_diff;
    assign w_dbg_diff = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (!srst) begin
            if (r_count > FULL_CNT)   $error("xfire_in_fifo: count above DEPTH");
            if (w_push && w_full)     $error("xfire_in_fifo: push while full");
            if (w_pop && w_empty)     $error("xfire_in_fifo: pop while empty");
            if (r_count != (CNT_W'(w_dbg_diff) + (w_full ? FULL_CNT : {CNT_W{1'b0}})))
                $error("xfire_in_fifo: count disagrees with pointers");
        end
    end
`endif

endmodule

// File: tb/tb_xfire_in_fifo.sv
// Scoreboard bench for xfire_in_fifo: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the FIFO.
module tb_xfire_in_fifo;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int CNT_W    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              srst;
    logic              enable;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              overflow;

    xfire_in_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .srst(srst), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: committed contents in order, plus sticky overflow.
    logic [DATA_W-1:0] q[$];
    logic              m_ovf  = 1'b0;
    logic              mon_en = 1'b0;
    int                n_vec  = 0;
    int                n_err  = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // Drive one cycle of inputs, then update the model after the clock edge.
    task automatic step(input logic rs, input logic en, input logic iv,
                        input logic [DATA_W-1:0] d, input logic ordy);
        logic p, o;
        srst = rs; enable = en; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        p = !rs && en && iv && (q.size() < DEPTH);
        o = !rs && en && iv && (q.size() == DEPTH);
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (p) q.push_back(d);
            if (o) m_ovf = 1'b1;
        end
    endtask

    // Monitor: status checks every cycle, head-word check, pop on model handshake.
    initial begin
        int sz;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                sz = q.size();
                chk("count",       32'(count),       32'(sz));
                chk("in_ready",    32'(in_ready),    32'(enable && sz < DEPTH));
                chk("out_valid",   32'(out_valid),   32'(enable && sz != 0));
                chk("almost_full", 32'(almost_full), 32'(sz >= AFULL_TH));
                chk("overflow",    32'(overflow),    32'(m_ovf));
                if (enable && sz != 0) begin
                    chk("out_data", 32'(out_data), 32'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        srst = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b0;

        // Reset with in_valid held high
        step(1, 1, 1, 16'h5555, 0);
        mon_en = 1'b1;
        step(1, 1, 1, 16'h6666, 1);
        step(0, 1, 0, 16'h0, 0);

        // Fill then drain
        for (int i = 1; i <= 4; i++) step(0, 1, 1, DATA_W'(i), 0);
        step(0, 1, 1, 16'h0005, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0, 1);

        // Single-word latency, then streaming across several wraps
        step(0, 1, 1, 16'hABCD, 0);
        step(0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 16'h1000 + DATA_W'(i), 1);
        step(0, 1, 0, 16'h0, 1);
        step(0, 1, 0, 16'h0, 1);

        // Overflow while full; the dropped word must never appear
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'h2000 + DATA_W'(i), 0);
        step(0, 1, 1, 16'hDEAD, 0);
        step(0, 1, 1, 16'hDEAD, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0, 1);

        // Enable freeze with count = 2
        step(0, 1, 1, 16'h3001, 0);
        step(0, 1, 1, 16'h3002, 0);
        step(0, 0, 1, 16'h3003, 1);
        step(0, 0, 0, 16'h3004, 0);
        step(0, 0, 1, 16'h3005, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 1);

        // Reset mid-stream with concurrent push and pop
        for (int i = 0; i < 3; i++) step(0, 1, 1, 16'h4000 + DATA_W'(i), 0);
        step(1, 1, 1, 16'h4444, 1);
        step(0, 1, 1, 16'h1234, 0);
        step(0, 1, 0, 16'h0, 1);
        step(0, 1, 0, 16'h0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) != 0),
                 DATA_W'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        step(0, 1, 0, 16'h0, 1);
        step(0, 1, 0, 16'h0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
